fsm_password_lock_param: RTL and testbench

- Parametrised successor to the 4-digit password lock FSM.
- Generalises the digit count, digit width, attempt limit and default password.
- Adds timed lockout with auto-release (0 = permanent until reset), a timed unlock window, an entry-abort input and password programming while unlocked.
- Sits between the keypad/strobe front end and the LED/alarm drivers.

---
 rtl/lock_pkg.sv | 24 ++
 rtl/lock_timer.sv | 42 ++++
 rtl/fsm_password_lock_param.sv | 197 +++++++++++++++++++
 tb/tb_fsm_password_lock_param.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and width helpers for the parametrised password lock.
package lock_pkg;

    typedef enum logic [2:0] {
        ENTRY    = 3'd0,
        CHECK    = 3'd1,
        ERROR    = 3'd2,
        UNLOCKED = 3'd3,
        SET      = 3'd4,
        LOCKED   = 3'd5
    } lock_state_e;

    // Number of bits needed to hold every value 0..value (never less than one).
    function automatic int bits_for(input int value);
        bits_for = (value < 2) ? 1 : $clog2(value + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the ERROR, UNLOCKED and LOCKED phases.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         hold,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins, then hold, otherwise count down and rest at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (hold) begin
            count_d = count_q;
        end else if (count_q != W'(0)) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= W'(0);
        end else begin
            count_q <= count_d;
        end
    end

    // A value of 1 marks the last cycle of a phase; a zero load never expires.
    assign expire = (count_q == W'(1)) && !hold && !load;

endmodule

// File: rtl/fsm_password_lock_param.sv
// Parametrised password lock: digit entry, attempt limiting, timed lockout,
// timed unlock window and password programming while unlocked.
module fsm_password_lock_param
    import lock_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_ATTEMPTS   = 3,
    parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_PASS = 16'h1234,
    parameter int UNLOCK_CYCLES  = 16,
    parameter int ERR_CYCLES     = 4,
    parameter int LOCKOUT_CYCLES = 64,
    localparam int ATT_W         = bits_for(MAX_ATTEMPTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DIGIT_W-1:0]           digit,
    input  logic                         enter,
    input  logic                         clear,
    input  logic                         set_pass,
    input  logic                         view_pass,
    output logic                         green_led,
    output logic                         red_led,
    output logic                         alarm,
    output logic [N_DIGITS*DIGIT_W-1:0]  viewed_pass,
    output logic [ATT_W-1:0]             attempts_left
);

    localparam int PASS_W = N_DIGITS * DIGIT_W;
    localparam int CNT_W  = bits_for(N_DIGITS);
    localparam int TMR_W  = bits_for(max3(UNLOCK_CYCLES, ERR_CYCLES, LOCKOUT_CYCLES));

    lock_state_e       state_q, state_d;
    logic [PASS_W-1:0] buffer_q, buffer_d;
    logic [PASS_W-1:0] stored_q, stored_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ATT_W-1:0]  attempts_q, attempts_d;
    logic              green_q, green_d;
    logic              red_q, red_d;
    logic              alarm_q, alarm_d;

    logic              tmr_load_s;
    logic              tmr_hold_s;
    logic [TMR_W-1:0]  tmr_val_s;
    logic              tmr_expire_s;
    logic [PASS_W-1:0] shifted_s;
    logic              last_digit_s;

    lock_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .hold     (tmr_hold_s),
        .expire   (tmr_expire_s)
    );

    // New digits enter at the bottom so the first digit ends up most significant.
    assign shifted_s    = (buffer_q << DIGIT_W) | PASS_W'(digit);
    assign last_digit_s = (count_q == CNT_W'(N_DIGITS - 1));

    // Next-state, datapath and output decode.
    always_comb begin
        state_d    = state_q;
        buffer_d   = buffer_q;
        count_d    = count_q;
        stored_d   = stored_q;
        attempts_d = attempts_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = TMR_W'(0);
        tmr_hold_s = 1'b0;
        case (state_q)
            ENTRY: begin
                if (clear) begin
                    buffer_d = '0;
                    count_d  = CNT_W'(0);
                end else if (enter) begin
                    buffer_d = shifted_s;
                    if (last_digit_s) begin
                        count_d = CNT_W'(0);
                        state_d = CHECK;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    buffer_d = buffer_q;
                end
            end
            CHECK: begin
                buffer_d   = '0;
                count_d    = CNT_W'(0);
                tmr_load_s = 1'b1;
                if (buffer_q == stored_q) begin
                    state_d    = UNLOCKED;
                    attempts_d = ATT_W'(MAX_ATTEMPTS);
                    tmr_val_s  = TMR_W'(UNLOCK_CYCLES);
                end else if (attempts_q == ATT_W'(1)) begin
                    state_d    = LOCKED;
                    attempts_d = ATT_W'(0);
                    tmr_val_s  = TMR_W'(LOCKOUT_CYCLES);
                end else begin
                    state_d    = ERROR;
                    attempts_d = attempts_q - ATT_W'(1);
                    tmr_val_s  = TMR_W'(ERR_CYCLES);
                end
            end
            ERROR: begin
                if (tmr_expire_s) begin
                    state_d = ENTRY;
                end else begin
                    state_d = ERROR;
                end
            end
            UNLOCKED: begin
                if (set_pass) begin
                    state_d    = SET;
                    tmr_hold_s = 1'b1;
                    buffer_d   = '0;
                    count_d    = CNT_W'(0);
                end else if (tmr_expire_s) begin
                    state_d = ENTRY;
                end else begin
                    state_d = UNLOCKED;
                end
            end
            SET: begin
                tmr_hold_s = 1'b1;
                if (clear) begin
                    state_d  = ENTRY;
                    buffer_d = '0;
                    count_d  = CNT_W'(0);
                end else if (enter) begin
                    if (last_digit_s) begin
                        stored_d = shifted_s;
                        buffer_d = '0;
                        count_d  = CNT_W'(0);
                        state_d  = ENTRY;
                    end else begin
                        buffer_d = shifted_s;
                        count_d  = count_q + CNT_W'(1);
                    end
                end else begin
                    state_d = SET;
                end
            end
            LOCKED: begin
                // With a zero lockout the timer never reaches 1, so this holds until reset.
                if (tmr_expire_s) begin
                    state_d    = ENTRY;
                    attempts_d = ATT_W'(MAX_ATTEMPTS);
                    buffer_d   = '0;
                    count_d    = CNT_W'(0);
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d  = ENTRY;
                buffer_d = '0;
                count_d  = CNT_W'(0);
            end
        endcase
        green_d = (state_d == UNLOCKED) || (state_d == SET);
        red_d   = (state_d == ERROR) || (state_d == LOCKED);
        alarm_d = (state_d == LOCKED);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ENTRY;
            buffer_q   <= '0;
            stored_q   <= DEFAULT_PASS;
            count_q    <= CNT_W'(0);
            attempts_q <= ATT_W'(MAX_ATTEMPTS);
            green_q    <= 1'b0;
            red_q      <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            buffer_q   <= buffer_d;
            stored_q   <= stored_d;
            count_q    <= count_d;
            attempts_q <= attempts_d;
            green_q    <= green_d;
            red_q      <= red_d;
            alarm_q    <= alarm_d;
        end
    end

    assign green_led     = green_q;
    assign red_led       = red_q;
    assign alarm         = alarm_q;
    assign attempts_left = attempts_q;
    assign viewed_pass   = (green_q && view_pass) ? stored_q : '0;

endmodule

// File: tb/tb_fsm_password_lock_param.sv
// Randomised and directed bench for fsm_password_lock_param, checked every
// cycle against a behavioural model of the lock's rules.
module tb_fsm_password_lock_param;

    typedef struct {
        int          n;
        int          maxatt;
        int          ucyc;
        int          ecyc;
        int          lcyc;
        logic [23:0] dflt;
    } cfg_t;

    typedef struct {
        logic [23:0] stored;
        logic [23:0] val;
        int          cnt;
        bit          checking;
        bit          programming;
        int          unlock_left;
        int          err_left;
        int          lock_left;   // -1 means locked until reset
        int          att;
    } mdl_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic        set_pass = 1'b0;
    logic        view_pass = 1'b0;
    logic [3:0]  digit = 4'd0;

    logic        green0, red0, alarm0;
    logic [15:0] viewed0;
    logic [1:0]  att0;
    logic        green1, red1, alarm1;
    logic [23:0] viewed1;
    logic [1:0]  att1;

    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;
    cfg_t c0, c1;
    mdl_t m0, m1;

    always #5 clk = ~clk;

    fsm_password_lock_param dut0 (
        .clk(clk), .reset(reset), .digit(digit), .enter(enter), .clear(clear),
        .set_pass(set_pass), .view_pass(view_pass), .green_led(green0),
        .red_led(red0), .alarm(alarm0), .viewed_pass(viewed0), .attempts_left(att0)
    );

    fsm_password_lock_param #(
        .N_DIGITS(6), .DIGIT_W(4), .DEFAULT_PASS(24'h123456), .LOCKOUT_CYCLES(0)
    ) dut1 (
        .clk(clk), .reset(reset), .digit(digit), .enter(enter), .clear(clear),
        .set_pass(set_pass), .view_pass(view_pass), .green_led(green1),
        .red_led(red1), .alarm(alarm1), .viewed_pass(viewed1), .attempts_left(att1)
    );

    function automatic mdl_t m_init(input cfg_t c);
        mdl_t r;
        r.stored = c.dflt; r.val = 24'd0; r.cnt = 0;
        r.checking = 1'b0; r.programming = 1'b0;
        r.unlock_left = 0; r.err_left = 0; r.lock_left = 0;
        r.att = c.maxatt;
        return r;
    endfunction

    function automatic mdl_t m_step(input mdl_t m, input cfg_t c, input bit en,
                                    input bit clr, input bit sp, input logic [3:0] d);
        mdl_t r;
        r = m;
        if (r.checking) begin
            r.checking = 1'b0;
            if (r.val == r.stored) begin
                r.unlock_left = c.ucyc;
                r.att = c.maxatt;
            end else begin
                r.att = r.att - 1;
                if (r.att == 0) r.lock_left = (c.lcyc == 0) ? -1 : c.lcyc;
                else r.err_left = c.ecyc;
            end
            r.val = 24'd0; r.cnt = 0;
        end else if (r.lock_left != 0) begin
            if (r.lock_left > 0) begin
                r.lock_left = r.lock_left - 1;
                if (r.lock_left == 0) r.att = c.maxatt;
            end
        end else if (r.err_left > 0) begin
            r.err_left = r.err_left - 1;
        end else if (r.programming) begin
            if (clr) begin
                r.programming = 1'b0; r.val = 24'd0; r.cnt = 0;
            end else if (en) begin
                r.val = r.val * 24'd16 + 24'(d);
                r.cnt = r.cnt + 1;
                if (r.cnt == c.n) begin
                    r.stored = r.val; r.programming = 1'b0; r.val = 24'd0; r.cnt = 0;
                end
            end
        end else if (r.unlock_left > 0) begin
            if (sp) begin
                r.programming = 1'b1; r.unlock_left = 0; r.val = 24'd0; r.cnt = 0;
            end else begin
                r.unlock_left = r.unlock_left - 1;
            end
        end else begin
            if (clr) begin
                r.val = 24'd0; r.cnt = 0;
            end else if (en) begin
                r.val = r.val * 24'd16 + 24'(d);
                r.cnt = r.cnt + 1;
                if (r.cnt == c.n) r.checking = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic bit m_green(input mdl_t m);
        return (m.unlock_left > 0) || m.programming;
    endfunction
    function automatic bit m_red(input mdl_t m);
        return (m.err_left > 0) || (m.lock_left != 0);
    endfunction
    function automatic bit m_alarm(input mdl_t m);
        return m.lock_left != 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on the same edges the DUTs sample.
    always @(posedge clk) begin
        if (!reset) begin
            m0 = m_init(c0);
            m1 = m_init(c1);
        end else begin
            m0 = m_step(m0, c0, enter, clear, set_pass, digit);
            m1 = m_step(m1, c1, enter, clear, set_pass, digit);
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (cmp_en && reset) begin
            chk("green0", 32'(green0), 32'(m_green(m0)));
            chk("red0", 32'(red0), 32'(m_red(m0)));
            chk("alarm0", 32'(alarm0), 32'(m_alarm(m0)));
            chk("att0", 32'(att0), 32'(m0.att));
            chk("view0", 32'(viewed0), (m_green(m0) && view_pass) ? 32'(m0.stored) : 32'd0);
            chk("green1", 32'(green1), 32'(m_green(m1)));
            chk("red1", 32'(red1), 32'(m_red(m1)));
            chk("alarm1", 32'(alarm1), 32'(m_alarm(m1)));
            chk("att1", 32'(att1), 32'(m1.att));
            chk("view1", 32'(viewed1), (m_green(m1) && view_pass) ? 32'(m1.stored) : 32'd0);
        end
    end

    task automatic cyc(input bit en, input bit clr, input bit sp, input bit vw, input logic [3:0] d);
        enter = en; clear = clr; set_pass = sp; view_pass = vw; digit = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic code(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, 1'b0, 1'b0, 1'b0, v[i*4 +: 4]);
    endtask

    task automatic code_gap(input logic [23:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, v[i*4 +: 4]);
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
    endtask

    initial begin
        c0 = '{n: 4, maxatt: 3, ucyc: 16, ecyc: 4, lcyc: 64, dflt: 24'h001234};
        c1 = '{n: 6, maxatt: 3, ucyc: 16, ecyc: 4, lcyc: 0, dflt: 24'h123456};
        #1;
        do_reset();
        cmp_en = 1'b1;

        view_pass = 1'b1;
        #1;
        chk("rst_green", 32'(green0), 32'd0);
        chk("rst_red", 32'(red0 | alarm0), 32'd0);
        chk("rst_att", 32'(att0), 32'd3);
        chk("rst_view", 32'(viewed0), 32'd0);

        code(24'h1234, 4); idle(1);
        chk("ok_green", 32'(green0), 32'd1);
        chk("ok_att", 32'(att0), 32'd3);
        idle(20);

        code(24'h9999, 4); idle(1);
        chk("err1_red", 32'(red0), 32'd1);
        chk("err1_att", 32'(att0), 32'd2);
        chk("model_att", 32'(m0.att), 32'd2);
        idle(5);
        code(24'h8888, 4); idle(1);
        chk("err2_att", 32'(att0), 32'd1);
        idle(5);
        code(24'h1234, 4); idle(1);
        chk("reok_green", 32'(green0), 32'd1);
        chk("reok_att", 32'(att0), 32'd3);
        idle(20);

        code(24'h9999, 4); idle(6);
        code(24'h8888, 4); idle(6);
        code(24'h7777, 4); idle(1);
        chk("lock_alarm", 32'(alarm0), 32'd1);
        chk("lock_red", 32'(red0), 32'd1);
        chk("lock_att", 32'(att0), 32'd0);
        code(24'h1234, 4); idle(1);
        chk("lock_hold", 32'(alarm0), 32'd1);
        idle(60);
        chk("lock_end", 32'(alarm0), 32'd0);
        chk("lock_end_att", 32'(att0), 32'd3);
        code(24'h1234, 4); idle(1);
        chk("post_lock_green", 32'(green0), 32'd1);

        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        code(24'h5678, 4); idle(1);
        chk("set_done", 32'(green0), 32'd0);
        chk("model_stored", 32'(m0.stored), 32'h5678);
        code(24'h1234, 4); idle(1);
        chk("old_pass_att", 32'(att0), 32'd2);
        idle(5);
        code(24'h5678, 4); idle(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        chk("view_new", 32'(viewed0), 32'h5678);
        idle(20);

        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
        code(24'h1234, 4); idle(1);
        chk("clr_green", 32'(green0), 32'd1);
        chk("clr_att", 32'(att0), 32'd3);
        idle(20);

        for (int e = 0; e < 250; e++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r <= 6) begin
                code_gap(m0.stored, 4);
                idle(int'($urandom_range(1, 3)));
            end else if (r <= 10) begin
                code_gap(24'($urandom), 4);
            end else if (r <= 12) begin
                cyc(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 4'd0);
                if ($urandom_range(0, 3) == 0) begin
                    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'($urandom));
                    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
                end else begin
                    code_gap(24'($urandom), 4);
                end
            end else if (r <= 15) begin
                for (int k = 0; k < int'($urandom_range(1, 25)); k++)
                    cyc(1'b0, 1'b0, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 4'd0);
            end else if (r <= 18) begin
                for (int k = 0; k < int'($urandom_range(1, 8)); k++)
                    cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                        1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 4'($urandom));
            end else begin
                if ($urandom_range(0, 3) == 0) do_reset();
                else idle(3);
            end
        end

        do_reset();
        code(24'h999999, 6); idle(6);
        code(24'h888888, 6); idle(6);
        code(24'h777777, 6); idle(1);
        chk("p6_alarm", 32'(alarm1), 32'd1);
        idle(520);
        chk("p6_alarm_hold", 32'(alarm1), 32'd1);
        chk("p6_att_hold", 32'(att1), 32'd0);
        do_reset();
        chk("p6_rst_att", 32'(att1), 32'd3);
        chk("p6_rst_alarm", 32'(alarm1), 32'd0);
        code(24'h123456, 6); idle(1);
        chk("p6_green", 32'(green1), 32'd1);
        idle(4);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
